// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: synchronised edge capture, fixed priority with
// nesting, global enable via STI/CLI, held request with vector address to PC select.
module interrupt_controller #(
   parameter int unsigned N_IRQ      = 3,
   parameter logic [31:0] VEC_BASE   = 32'h0000_3000,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [N_IRQ-1:0]                         i_irq_in,
   input  logic                                     i_sti,
   input  logic                                     i_cli,
   input  logic                                     i_uret,
   input  logic                                     i_int_ack,
   output logic                                     o_int_req,
   output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] o_int_id,
   output logic [31:0]                              o_int_vec,
   output logic                                     o_ie,
   output logic [N_IRQ-1:0]                         o_pending,
   output logic [N_IRQ-1:0]                         o_in_service
);
   localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [ID_W-1:0]   w_id_nxt;
   logic [N_IRQ-1:0]  r_s1, r_s2, r_s3;
   logic [N_IRQ-1:0]  r_armed;
   logic              r_filled;
   logic [N_IRQ-1:0]  w_edge;
   logic [ID_W-1:0]   w_cand;
   logic              w_cand_vld;
   logic              w_blocked;
   logic              w_eligible;
   logic              w_ack_take;
   logic [N_IRQ-1:0]  w_ack_oh;
   logic [N_IRQ-1:0]  w_uret_clr;

   // A line must be seen low after reset before its rising edge counts, so a line
   // already high through reset release produces no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_s3     <= '0;
         r_armed  <= '0;
         r_filled <= 1'b0;
      end else begin
         r_s1     <= i_irq_in;
         r_s2     <= r_s1;
         r_s3     <= r_s2;
         r_filled <= 1'b1;
         r_armed  <= r_armed | (~r_s1 & {N_IRQ{r_filled}});
      end
   end

   assign w_edge = r_s2 & ~r_s3 & r_armed;

   // Candidate: lowest-index pending; lowest-index in-service for uret.
   always_comb begin
      w_cand_vld = 1'b0;
      w_cand     = '0;
      w_uret_clr = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (r_pending_bit(i)) begin
            w_cand_vld = 1'b1;
            w_cand     = ID_W'(i);
         end
         if (o_in_service[i]) begin
            w_uret_clr    = '0;
            w_uret_clr[i] = 1'b1;
         end
      end
   end

   function automatic logic r_pending_bit(input int idx);
      return o_pending[idx];
   endfunction

   always_comb begin
      w_blocked = 1'b0;
      for (int j = 0; j < N_IRQ; j++) begin
         if (o_in_service[j] && (32'(j) <= 32'(w_cand))) w_blocked = 1'b1;
      end
   end

   assign w_eligible = o_ie && w_cand_vld && !w_blocked;
   assign w_ack_take = (r_state == REQ) && i_int_ack;
   assign w_ack_oh   = w_ack_take ? (N_IRQ'(1) << o_int_id) : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = o_int_id;
      case (r_state)
         IDLE: begin
            if (w_eligible) begin
               w_state_nxt = REQ;
               w_id_nxt    = w_cand;
            end
         end
         REQ: begin
            if (i_int_ack || i_cli || !o_pending[o_int_id]) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         o_int_req <= 1'b0;
         o_int_id  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         o_int_req <= (w_state_nxt == REQ);
         o_int_id  <= w_id_nxt;
      end
   end

   // New edges win over ack clear; ack clear of ie wins over sti/uret.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_pending    <= '0;
         o_in_service <= '0;
         o_ie         <= 1'b0;
      end else begin
         o_pending    <= (o_pending & ~w_ack_oh) | w_edge;
         o_in_service <= (o_in_service & ~(i_uret ? w_uret_clr : '0)) | w_ack_oh;
         if (w_ack_take || i_cli) o_ie <= 1'b0;
         else if (i_sti || i_uret) o_ie <= 1'b1;
      end
   end

   assign o_int_vec = VEC_BASE + 32'(o_int_id) * VEC_STRIDE;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  irq_in;
   logic        sti, cli, uret, int_ack;
   logic        int_req;
   logic [1:0]  int_id;
   logic [31:0] int_vec;
   logic        ie;
   logic [2:0]  pending, in_service;

   int n_checks = 0;
   int n_fail   = 0;

   interrupt_controller #(.N_IRQ(3), .VEC_BASE(32'h0000_3000), .VEC_STRIDE(32'h0000_0100)) dut (
      .clk(clk), .rst_n(rst_n), .i_irq_in(irq_in), .i_sti(sti), .i_cli(cli),
      .i_uret(uret), .i_int_ack(int_ack), .o_int_req(int_req), .o_int_id(int_id),
      .o_int_vec(int_vec), .o_ie(ie), .o_pending(pending), .o_in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_sti();  sti = 1'b1;     step(1); sti = 1'b0;     endtask
   task automatic pulse_cli();  cli = 1'b1;     step(1); cli = 1'b0;     endtask
   task automatic pulse_uret(); uret = 1'b1;    step(1); uret = 1'b0;    endtask
   task automatic pulse_ack();  int_ack = 1'b1; step(1); int_ack = 1'b0; endtask

   initial begin
      rst_n = 1'b0; irq_in = '0; sti = 0; cli = 0; uret = 0; int_ack = 0;
      #12;
      check("rst_req", 32'(int_req), 0);
      check("rst_id", 32'(int_id), 0);
      check("rst_vec", int_vec, 32'h0000_3000);
      check("rst_ie", 32'(ie), 0);
      check("rst_pend", 32'(pending), 0);
      check("rst_isv", 32'(in_service), 0);
      rst_n = 1'b1;
      step(1);

      // basic request on source 1
      pulse_sti();
      check("sti_ie", 32'(ie), 1);
      irq_in[1] = 1'b1;
      step(3);
      check("t1_pend", 32'(pending), 3'b010);
      check("t1_req_early", 32'(int_req), 0);
      step(1);
      check("t1_req", 32'(int_req), 1);
      check("t1_id", 32'(int_id), 1);
      check("t1_vec", int_vec, 32'h0000_3100);
      pulse_ack();
      check("t1_ack_req", 32'(int_req), 0);
      check("t1_ack_isv", 32'(in_service), 3'b010);
      check("t1_ack_ie", 32'(ie), 0);
      check("t1_ack_pend", 32'(pending), 0);
      irq_in[1] = 1'b0;
      pulse_uret();
      check("t1_uret_isv", 32'(in_service), 0);
      check("t1_uret_ie", 32'(ie), 1);
      pulse_cli();
      check("cli_ie", 32'(ie), 0);

      // pending held while disabled, sti raises request two edges later
      irq_in[2] = 1'b1; step(1); irq_in[2] = 1'b0;
      step(3);
      check("t2_pend", 32'(pending), 3'b100);
      check("t2_noreq", 32'(int_req), 0);
      pulse_sti();
      check("t2_req_not_yet", 32'(int_req), 0);
      step(1);
      check("t2_req", 32'(int_req), 1);
      check("t2_vec", int_vec, 32'h0000_3200);

      // withdraw by cli, then sti+cli together
      pulse_cli();
      check("t5_withdraw", 32'(int_req), 0);
      check("t5_pend_kept", 32'(pending), 3'b100);
      sti = 1'b1; cli = 1'b1; step(1); sti = 1'b0; cli = 1'b0;
      check("t5_cli_wins", 32'(ie), 0);
      pulse_sti();
      step(1);
      check("t5_rereq", 32'(int_req), 1);
      check("t5_reid", 32'(int_id), 2);
      pulse_ack();
      check("t5_isv", 32'(in_service), 3'b100);
      pulse_uret();
      check("t5_uret_isv", 32'(in_service), 0);

      // nesting
      irq_in[1] = 1'b1;
      step(4);
      check("t3_req1", 32'(int_req), 1);
      check("t3_id1", 32'(int_id), 1);
      pulse_ack();
      irq_in[1] = 1'b0;
      check("t3_isv1", 32'(in_service), 3'b010);
      pulse_sti();
      irq_in[2] = 1'b1; step(1); irq_in[2] = 1'b0;
      step(4);
      check("t3_p2_blocked", 32'(int_req), 0);
      check("t3_p2_pend", 32'(pending), 3'b100);
      irq_in[0] = 1'b1; step(1); irq_in[0] = 1'b0;
      step(3);
      check("t3_req0", 32'(int_req), 1);
      check("t3_id0", 32'(int_id), 0);
      check("t3_vec0", int_vec, 32'h0000_3000);
      pulse_ack();
      check("t3_isv_nest", 32'(in_service), 3'b011);
      check("t3_pend_after", 32'(pending), 3'b100);
      pulse_uret();
      check("t3_uret1_isv", 32'(in_service), 3'b010);
      check("t3_uret1_ie", 32'(ie), 1);
      step(2);
      check("t3_still_blocked", 32'(int_req), 0);
      pulse_uret();
      check("t3_uret2_isv", 32'(in_service), 0);
      step(1);
      check("t3_req2", 32'(int_req), 1);
      check("t3_id2", 32'(int_id), 2);
      pulse_ack();
      pulse_uret();

      // simultaneous edges: priority then the other
      irq_in[0] = 1'b1; irq_in[2] = 1'b1; step(1); irq_in = '0;
      step(3);
      check("t4_pend", 32'(pending), 3'b101);
      check("t4_id0", 32'(int_id), 0);
      check("t4_req", 32'(int_req), 1);
      pulse_ack();
      check("t4_pend_after", 32'(pending), 3'b100);
      pulse_uret();
      step(1);
      check("t4_req2", 32'(int_req), 1);
      check("t4_id2", 32'(int_id), 2);
      int_ack = 1'b1; sti = 1'b1; step(1); int_ack = 1'b0; sti = 1'b0;
      check("t4_ack_beats_sti", 32'(ie), 0);
      check("t4_isv", 32'(in_service), 3'b100);
      pulse_uret();

      // id frozen in REQ, then async reset mid-request
      irq_in[1] = 1'b1; step(1); irq_in[1] = 1'b0;
      step(3);
      check("t6_req1", 32'(int_req), 1);
      irq_in[0] = 1'b1;
      step(4);
      check("t6_frozen_id", 32'(int_id), 1);
      check("t6_frozen_pend", 32'(pending), 3'b011);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_req", 32'(int_req), 0);
      check("t6_rst_pend", 32'(pending), 0);
      check("t6_rst_ie", 32'(ie), 0);
      #2 rst_n = 1'b1;
      step(6);
      check("t6_held_no_edge", 32'(pending), 0);
      irq_in[0] = 1'b0;
      step(3);
      irq_in[0] = 1'b1;
      step(3);
      check("t6_new_edge", 32'(pending), 3'b001);
      check("t6_noreq_ie0", 32'(int_req), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
